// File: rtl/tpum_pkg.sv
// Shared definitions for the TriplePuM vector transfer block: register
// indices, CTRL/STATUS bit positions and the transfer FSM state type.
package tpum_pkg;

  localparam int IDX_CTRL   = 0;
  localparam int IDX_VSEL   = 1;
  localparam int IDX_XADDR  = 2;
  localparam int IDX_COUNT  = 3;
  localparam int IDX_STATUS = 4;
  localparam int VEC_BASE   = 8;

  localparam int CTRL_START = 0;
  localparam int CTRL_DIR   = 1;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } xfer_state_t;

endpackage

// File: rtl/tpum_apb_regs.sv
// APB slave for the vector transfer block: address decode, error response,
// control/status registers and the vector register file with its read mux.
// Also offers a load write port and a vector read port to the transfer FSM.
module tpum_apb_regs #(
  parameter int VEC_W   = 1024,
  parameter int NUM_VEC = 3,
  parameter int XBOX_AW = 14,
  parameter int APB_AW  = 12,
  parameter int VIW     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [APB_AW-1:0]  paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic               busy,
  output logic               start_go,
  output logic               start_dir,
  output logic [31:0]        vsel_q,
  output logic [XBOX_AW-1:0] xaddr_q,
  output logic [31:0]        count_q,
  input  logic               done_set,
  input  logic               err_set,
  input  logic               ld_we,
  input  logic [VIW-1:0]     ld_v,
  input  logic [VEC_W-1:0]   ld_data,
  input  logic [VIW-1:0]     rd_v,
  output logic [VEC_W-1:0]   rd_data
);
  import tpum_pkg::*;

  localparam int WORDS   = VEC_W / 32;
  localparam int VEC_END = VEC_BASE + NUM_VEC * WORDS;

  logic [31:0]      idx_i;
  logic             access, in_vec, bad_idx, ctl_wr_idx, err_resp, wr_ok;
  logic             range_err, start_err, w1c_done, w1c_err;
  logic             dir_q, done_q, err_q;
  logic [31:0]      rd_word;
  logic [VEC_W-1:0] vec [NUM_VEC];
  logic             unused_addr;

  assign unused_addr = ^paddr[1:0];
  assign idx_i       = 32'(paddr[APB_AW-1:2]);
  assign access      = psel & penable;
  assign in_vec      = (idx_i >= VEC_BASE) && (idx_i < VEC_END);
  assign bad_idx     = (idx_i >= VEC_END);
  assign ctl_wr_idx  = (idx_i == IDX_CTRL) || (idx_i == IDX_VSEL) ||
                       (idx_i == IDX_XADDR) || (idx_i == IDX_COUNT);
  // Out-of-map accesses always fail; configuration and vector writes fail while a transfer runs.
  assign err_resp    = bad_idx | (pwrite & busy & (in_vec | ctl_wr_idx));
  assign pready      = access;
  assign pslverr     = access & err_resp;
  assign wr_ok       = access & pwrite & ~err_resp;

  assign range_err   = ({1'b0, vsel_q} + {1'b0, count_q}) > 33'(NUM_VEC);
  assign start_go    = wr_ok & (idx_i == IDX_CTRL) & pwdata[CTRL_START] & ~range_err;
  assign start_err   = wr_ok & (idx_i == IDX_CTRL) & pwdata[CTRL_START] & range_err;
  assign start_dir   = pwdata[CTRL_DIR];
  assign w1c_done    = wr_ok & (idx_i == IDX_STATUS) & pwdata[ST_DONE];
  assign w1c_err     = wr_ok & (idx_i == IDX_STATUS) & pwdata[ST_ERR];

  // Control/status registers; sticky flags let a same-cycle set win over W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q   <= 1'b0;
      vsel_q  <= '0;
      xaddr_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (wr_ok && idx_i == IDX_CTRL)  dir_q   <= pwdata[CTRL_DIR];
      if (wr_ok && idx_i == IDX_VSEL)  vsel_q  <= pwdata;
      if (wr_ok && idx_i == IDX_XADDR) xaddr_q <= pwdata[XBOX_AW-1:0];
      if (wr_ok && idx_i == IDX_COUNT) count_q <= pwdata;
      done_q <= (done_q & ~w1c_done) | done_set;
      err_q  <= (err_q & ~w1c_err) | err_set | start_err;
    end
  end

  // Vector file: whole-row writes from XBOX loads, word writes from APB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VEC; v++) vec[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VEC; v++) begin
        if (ld_we && ld_v == VIW'(v)) vec[v] <= ld_data;
        for (int w = 0; w < WORDS; w++) begin
          if (wr_ok && idx_i == 32'(VEC_BASE + v * WORDS + w)) vec[v][w*32 +: 32] <= pwdata;
        end
      end
    end
  end

  // APB read mux, driven only during the access phase.
  always_comb begin
    rd_word = '0;
    if (idx_i == IDX_CTRL) begin
      rd_word[CTRL_DIR] = dir_q;
    end else if (idx_i == IDX_VSEL) begin
      rd_word = vsel_q;
    end else if (idx_i == IDX_XADDR) begin
      rd_word[XBOX_AW-1:0] = xaddr_q;
    end else if (idx_i == IDX_COUNT) begin
      rd_word = count_q;
    end else if (idx_i == IDX_STATUS) begin
      rd_word[ST_BUSY] = busy;
      rd_word[ST_DONE] = done_q;
      rd_word[ST_ERR]  = err_q;
    end else begin
      for (int v = 0; v < NUM_VEC; v++) begin
        for (int w = 0; w < WORDS; w++) begin
          if (idx_i == 32'(VEC_BASE + v * WORDS + w)) rd_word = vec[v][w*32 +: 32];
        end
      end
    end
    prdata = access ? rd_word : 32'd0;
  end

  // Whole-vector read port feeding the XBOX store data.
  always_comb begin
    rd_data = vec[0];
    for (int v = 0; v < NUM_VEC; v++) begin
      if (rd_v == VIW'(v)) rd_data = vec[v];
    end
  end

endmodule

// File: rtl/tpum_vec_xfer.sv
// Top of the TriplePuM vector transfer block: APB register file plus the
// row-by-row transfer FSM between the vector file and XBOX memory.
// Optional: define TPUM_XBOX_TIMEOUT_EN to abort a row that is not acked
// within TIMEOUT_CYC cycles (sets ERR and DONE).
module tpum_vec_xfer #(
  parameter int VEC_W       = 1024,
  parameter int NUM_VEC     = 3,
  parameter int XBOX_AW     = 14,
  parameter int APB_AW      = 12,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [APB_AW-1:0]  paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               xbox_req,
  output logic               xbox_we,
  output logic [XBOX_AW-1:0] xbox_addr,
  output logic [VEC_W-1:0]   xbox_wdata,
  input  logic [VEC_W-1:0]   xbox_rdata,
  input  logic               xbox_ack,
  output logic               irq_done
);
  import tpum_pkg::*;

  localparam int VIW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

  xfer_state_t        state_q, state_d;
  logic [VIW-1:0]     cur_v_q, cur_v_d;
  logic [XBOX_AW-1:0] cur_a_q, cur_a_d;
  logic [31:0]        rem_q, rem_d;
  logic               dir_q, dir_d;
  logic               irq_q;
  logic               busy, start_go, start_dir, done_set, err_set, ld_we, tmo_hit;
  logic [31:0]        vsel_q, count_q;
  logic [XBOX_AW-1:0] xaddr_q;
  logic               unused_vsel;

  assign unused_vsel = ^vsel_q[31:VIW];
  assign busy        = (state_q == S_REQ);
  assign xbox_req    = busy;
  assign xbox_we     = busy & dir_q;
  assign xbox_addr   = cur_a_q;
  assign irq_done    = irq_q;

  tpum_apb_regs #(
    .VEC_W   (VEC_W),
    .NUM_VEC (NUM_VEC),
    .XBOX_AW (XBOX_AW),
    .APB_AW  (APB_AW),
    .VIW     (VIW)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .busy      (busy),
    .start_go  (start_go),
    .start_dir (start_dir),
    .vsel_q    (vsel_q),
    .xaddr_q   (xaddr_q),
    .count_q   (count_q),
    .done_set  (done_set),
    .err_set   (err_set),
    .ld_we     (ld_we),
    .ld_v      (cur_v_q),
    .ld_data   (xbox_rdata),
    .rd_v      (cur_v_q),
    .rd_data   (xbox_wdata)
  );

`ifdef TPUM_XBOX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));

  // Ack watchdog: counts consecutive REQ cycles without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       tmo_q <= '0;
    else if (busy && !xbox_ack)       tmo_q <= tmo_q + TW'(1);
    else                              tmo_q <= '0;
  end
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif

  // Transfer state, row cursor and completion pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_v_q <= '0;
      cur_a_q <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_v_q <= cur_v_d;
      cur_a_q <= cur_a_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      irq_q   <= done_set;
    end
  end

  // Next-state logic: latch the job on START, advance one row per ack.
  always_comb begin
    state_d  = state_q;
    cur_v_d  = cur_v_q;
    cur_a_d  = cur_a_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    done_set = 1'b0;
    err_set  = 1'b0;
    ld_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          cur_v_d = vsel_q[VIW-1:0];
          cur_a_d = xaddr_q;
          rem_d   = count_q;
          dir_d   = start_dir;
          if (count_q == 32'd0) done_set = 1'b1;
          else                  state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (xbox_ack) begin
          ld_we   = ~dir_q;
          cur_v_d = cur_v_q + VIW'(1);
          cur_a_d = cur_a_q + XBOX_AW'(1);
          rem_d   = rem_q - 32'd1;
          if (rem_q == 32'd1) begin
            state_d  = S_IDLE;
            done_set = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d  = S_IDLE;
          done_set = 1'b1;
          err_set  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tpum_vec_xfer.sv
// Scoreboard bench for tpum_vec_xfer: stimulus pushes expected APB responses,
// XBOX row requests and irq pulses into queues; a monitor pops and compares.
module tb_tpum_vec_xfer;

  localparam int VEC_W = 1024;
  localparam int NV    = 3;
  localparam int WORDS = VEC_W / 32;
  localparam int VEND  = 8 + NV * WORDS;

  typedef struct { logic [31:0] data; bit chk; bit err; string name; } apb_exp_t;
  typedef struct { bit we; logic [13:0] addr; logic [VEC_W-1:0] wdata; } xb_exp_t;
  typedef struct { int delay; logic [VEC_W-1:0] data; } rsp_t;
  typedef struct { string name; int kind; logic exp; } lvl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic pready, pslverr, xbox_req, xbox_we, irq_done;
  logic [13:0] xbox_addr;
  logic [VEC_W-1:0] xbox_wdata;
  logic [VEC_W-1:0] xbox_rdata = '0;
  logic xbox_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  apb_exp_t apb_q[$];
  xb_exp_t  xbox_q[$];
  rsp_t     rsp_q[$];
  lvl_t     lvl_q[$];
  bit       irq_q[$];

  // Reference state
  logic [VEC_W-1:0] mv [NV];
  logic [31:0] m_vsel, m_xaddr, m_count;
  bit m_dir, m_done, m_err, m_busy;

  tpum_vec_xfer dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .xbox_req(xbox_req), .xbox_we(xbox_we), .xbox_addr(xbox_addr), .xbox_wdata(xbox_wdata),
    .xbox_rdata(xbox_rdata), .xbox_ack(xbox_ack), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int first_diff(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    for (int w = 0; w < WORDS; w++) if (a[w*32 +: 32] !== b[w*32 +: 32]) return w;
    return 0;
  endfunction

  // XBOX responder: acks each row after its scripted delay.
  int wait_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      xbox_ack = 1'b0;
      wait_cnt = 0;
    end else if (xbox_req && rsp_q.size() > 0) begin
      if (wait_cnt >= rsp_q[0].delay) begin
        xbox_ack   = 1'b1;
        xbox_rdata = rsp_q[0].data;
        void'(rsp_q.pop_front());
        wait_cnt   = 0;
      end else begin
        xbox_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      xbox_ack = 1'b0;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    apb_exp_t ea;
    xb_exp_t  ex;
    lvl_t     el;
    int       dw;
    while (lvl_q.size() > 0) begin
      el = lvl_q.pop_front();
      checks++;
      if (el.kind == 0) begin
        if (xbox_req !== el.exp) begin
          errors++;
          $display("FAIL %s: xbox_req=%b required %b", el.name, xbox_req, el.exp);
        end
      end else begin
        if (irq_q.size() != 0 || xbox_q.size() != 0 || rsp_q.size() != 0 || apb_q.size() != 0) begin
          errors++;
          $display("FAIL %s: pending irq=%0d rows=%0d rsp=%0d apb=%0d, required all 0",
                   el.name, irq_q.size(), xbox_q.size(), rsp_q.size(), apb_q.size());
          irq_q.delete(); xbox_q.delete(); rsp_q.delete();
        end
      end
    end
    if (rst_n) begin
      if (psel && penable) begin
        checks++;
        if (pready !== 1'b1) begin
          errors++;
          $display("FAIL pready: got %b required 1", pready);
        end
        checks++;
        if (apb_q.size() == 0) begin
          errors++;
          $display("FAIL apb_unexpected: access with no expectation");
        end else begin
          ea = apb_q.pop_front();
          if (pslverr !== ea.err || (ea.chk && prdata !== ea.data)) begin
            errors++;
            $display("FAIL %s: prdata=%h pslverr=%b required prdata=%h pslverr=%b",
                     ea.name, prdata, pslverr, ea.data, ea.err);
          end
        end
      end
      if (xbox_req) begin
        checks++;
        if (xbox_q.size() == 0) begin
          errors++;
          $display("FAIL xbox_unexpected: req addr=%h with no row expected", xbox_addr);
        end else begin
          ex = xbox_q[0];
          if (xbox_addr !== ex.addr || xbox_we !== ex.we) begin
            errors++;
            $display("FAIL xbox_row: addr=%h we=%b required addr=%h we=%b", xbox_addr, xbox_we, ex.addr, ex.we);
          end
          if (ex.we) begin
            checks++;
            if (xbox_wdata !== ex.wdata) begin
              dw = first_diff(xbox_wdata, ex.wdata);
              errors++;
              $display("FAIL xbox_wdata: word %0d got %h required %h", dw,
                       xbox_wdata[dw*32 +: 32], ex.wdata[dw*32 +: 32]);
            end
          end
          if (xbox_ack) void'(xbox_q.pop_front());
        end
      end
      if (irq_done) begin
        checks++;
        if (irq_q.size() == 0) begin
          errors++;
          $display("FAIL irq_done: got unexpected pulse, required 0");
        end else begin
          void'(irq_q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] mread(input int idx);
    logic [31:0] r;
    int off;
    r = '0;
    if (idx == 0)      r[1] = m_dir;
    else if (idx == 1) r = m_vsel;
    else if (idx == 2) r = m_xaddr;
    else if (idx == 3) r = m_count;
    else if (idx == 4) r = {29'd0, m_err, m_done, m_busy};
    else if (idx >= 8 && idx < VEND) begin
      off = idx - 8;
      r = mv[off / WORDS][(off % WORDS) * 32 +: 32];
    end
    return r;
  endfunction

  task automatic apb_access(input int idx, input bit wr, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = 12'(idx << 2); pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input int idx);
    apb_exp_t e;
    e.data = mread(idx); e.chk = 1'b1; e.err = (idx >= VEND);
    e.name = $sformatf("read[%0d]", idx);
    apb_q.push_back(e);
    apb_access(idx, 1'b0, 32'd0);
  endtask

  task automatic apb_write(input int idx, input logic [31:0] d);
    apb_exp_t e;
    int off;
    e.data = '0; e.chk = 1'b0;
    e.err  = (idx >= VEND) || (m_busy && (idx <= 3 || idx >= 8));
    e.name = $sformatf("write[%0d]", idx);
    apb_q.push_back(e);
    apb_access(idx, 1'b1, d);
    if (!e.err) begin
      if (idx == 0) begin
        m_dir = d[1];
        if (d[0] && (longint'(m_vsel) + longint'(m_count) > NV)) m_err = 1'b1;
      end else if (idx == 1) m_vsel = d;
      else if (idx == 2) m_xaddr = d & 32'h3FFF;
      else if (idx == 3) m_count = d;
      else if (idx == 4) begin
        if (d[1]) m_done = 1'b0;
        if (d[2]) m_err = 1'b0;
      end else if (idx >= 8) begin
        off = idx - 8;
        mv[off / WORDS][(off % WORDS) * 32 +: 32] = d;
      end
    end
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int w = 0; w < WORDS; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Configure and start a legal job; rows and rdata are scripted up front.
  task automatic start_xfer(input int vsel, input logic [31:0] xaddr, input int count,
                            input bit dir, input bit respond, input int dly);
    xb_exp_t x;
    rsp_t r;
    logic [13:0] a;
    apb_write(1, vsel);
    apb_write(2, xaddr);
    apb_write(3, count);
    a = xaddr[13:0];
    for (int i = 0; i < count; i++) begin
      x.we = dir; x.addr = a; x.wdata = dir ? mv[vsel + i] : '0;
      xbox_q.push_back(x);
      if (respond) begin
        r.delay = (dly < 0) ? $urandom_range(0, 4) : dly;
        r.data  = rand_vec();
        rsp_q.push_back(r);
        if (!dir) mv[vsel + i] = r.data;
      end
      a = a + 14'd1;
    end
    if (respond) irq_q.push_back(1'b1);
    apb_write(0, {30'd0, dir, 1'b1});
    if (respond) m_done = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    lvl_t l;
    int n = 0;
    while ((irq_q.size() != 0 || xbox_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    l.name = name; l.kind = 1; l.exp = 1'b0;
    lvl_q.push_back(l);
    @(posedge clk);
  endtask

  task automatic push_req_check(input string name, input logic v);
    lvl_t l;
    l.name = name; l.kind = 0; l.exp = v;
    lvl_q.push_back(l);
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) mv[v] = '0;
    m_vsel = '0; m_xaddr = '0; m_count = '0;
    m_dir = 1'b0; m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
  endtask

  initial begin
    int v, w, cnt;
    rsp_t r;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state: registers, reserved slots, all vector words, out-of-range error
    for (int i = 0; i < VEND; i++) apb_read(i);
    apb_read(VEND);
    apb_write(5, 32'hFFFF_FFFF);
    apb_read(5);

    // Vector 1 pattern fill and readback, then random words into vectors 0 and 2
    for (int i = 0; i < WORDS; i++) apb_write(8 + WORDS + i, 32'hA5A5_0000 + i);
    for (int i = 0; i < WORDS; i++) apb_read(8 + WORDS + i);
    for (int i = 0; i < 12; i++) begin
      v = ($urandom_range(0, 1) == 0) ? 0 : 2;
      w = $urandom_range(0, WORDS - 1);
      apb_write(8 + v * WORDS + w, $urandom);
      apb_read(8 + v * WORDS + w);
    end

    // Load two rows across the XBOX address wrap, acks after 0 then 3 cycles
    begin
      xb_exp_t x;
      apb_write(1, 0); apb_write(2, 32'h3FFF); apb_write(3, 2);
      x.we = 1'b0; x.wdata = '0;
      x.addr = 14'h3FFF; xbox_q.push_back(x);
      x.addr = 14'h0000; xbox_q.push_back(x);
      r.delay = 0; r.data = rand_vec(); rsp_q.push_back(r); mv[0] = r.data;
      r.delay = 3; r.data = rand_vec(); rsp_q.push_back(r); mv[1] = r.data;
      irq_q.push_back(1'b1);
      apb_write(0, 32'h1);
      m_done = 1'b1;
    end
    wait_done("load_done", 50);
    apb_read(4);
    apb_read(0);
    for (int i = 0; i < WORDS; i += 5) begin apb_read(8 + i); apb_read(8 + WORDS + i); end
    apb_write(4, 32'h2);
    apb_read(4);

    // Store vector 2, held stable across a delayed ack
    start_xfer(2, 32'h0100, 1, 1'b1, 1'b1, 4);
    wait_done("store_done", 50);
    apb_read(4);
    apb_write(4, 32'h6);

    // Random legal jobs, including zero-length ones
    for (int t = 0; t < 10; t++) begin
      cnt = $urandom_range(0, NV);
      start_xfer($urandom_range(0, NV - cnt), $urandom, cnt, 1'($urandom_range(0, 1)), 1'b1, -1);
      wait_done($sformatf("rand_done%0d", t), 100);
      apb_read(4);
      apb_read(8 + $urandom_range(0, NV * WORDS - 1));
      apb_write(4, 32'h6);
    end

    // Writes rejected while busy; reads still served
    start_xfer(0, 32'h0200, 1, 1'b0, 1'b0, 0);
    m_busy = 1'b1;
    apb_write(8 + 3, 32'hDEAD_BEEF);
    apb_write(3, 32'h7);
    apb_write(0, 32'h1);
    apb_write(1, 32'h2);
    apb_read(3);
    apb_read(8 + 3);
    apb_read(4);
    m_busy = 1'b0;
    r.delay = 0; r.data = rand_vec(); rsp_q.push_back(r); mv[0] = r.data;
    irq_q.push_back(1'b1);
    m_done = 1'b1;
    wait_done("busy_done", 50);
    apb_read(4);
    apb_read(8 + 3);
    apb_write(4, 32'h6);

    // Out-of-range job: ERR only, no XBOX traffic, no irq
    apb_write(1, 2); apb_write(3, 2);
    apb_write(0, 32'h1);
    repeat (5) @(posedge clk);
    apb_read(4);
    apb_write(4, 32'h4);
    apb_read(4);

    // Missing ack
    start_xfer(1, 32'h0010, 1, 1'b0, 1'b0, 0);
`ifdef TPUM_XBOX_TIMEOUT_EN
    irq_q.push_back(1'b1);
    repeat (240) @(posedge clk);
    push_req_check("tmo_early", 1'b1);
    for (int n = 0; n < 60 && xbox_req; n++) @(posedge clk);
    xbox_q.delete();
    push_req_check("tmo_drop", 1'b0);
    m_done = 1'b1; m_err = 1'b1;
    wait_done("tmo_irq", 10);
    apb_read(4);
    apb_read(8 + WORDS);
`else
    repeat (300) @(posedge clk);
    push_req_check("hang_req", 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    push_req_check("async_rst_req", 1'b0);
    @(negedge clk); #1;
    xbox_q.delete(); irq_q.delete(); rsp_q.delete();
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    apb_read(4);
    apb_read(8);
    apb_read(2);
`endif

    wait_done("final", 10);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
